// File: rtl/dmac_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmac_channel_arbiter
// Description : Round-robin DMA channel arbiter and sequencer. Picks one
//               requesting peripheral, obtains the system bus, acknowledges
//               the peripheral, enables its channel engine and records the
//               completion/error status with a sticky interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module dmac_channel_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] DmacReq,
    input  logic              Bus_Grant,
    input  logic              Ch_Done,
    input  logic              Ch_Error,
    input  logic              Int_Clr,
    output logic              Bus_Req,
    output logic [NUM_CH-1:0] ReqAck,
    output logic [NUM_CH-1:0] Ch_En,
    output logic [CH_W-1:0]   Ch_Sel,
    output logic              Ch_Hold,
    output logic              Interrupt,
    output logic [NUM_CH-1:0] Int_Status,
    output logic [NUM_CH-1:0] Err_Status
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_BUS = 3'd1,
        ACK     = 3'd2,
        ACTIVE  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    state_t            state_n;

    // Round-robin pointer: the channel served most recently.
    logic [CH_W-1:0]   last;
    logic [CH_W-1:0]   last_n;

    logic [CH_W-1:0]   rr_sel;
    logic              rr_found;
    logic [CH_W-1:0]   cand;

    logic              bus_req_n;
    logic [NUM_CH-1:0] ack_n;
    logic [NUM_CH-1:0] en_n;
    logic [CH_W-1:0]   sel_n;
    logic              done_set;
    logic              err_set;
    logic              irq_n;
    logic [NUM_CH-1:0] int_stat_n;
    logic [NUM_CH-1:0] err_stat_n;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Stall the engine whenever it is enabled but the bus has been taken away.
    assign Ch_Hold = (|Ch_En) && !Bus_Grant;

    // Round-robin search: first requesting channel after the last served one.
    always_comb begin
        rr_sel   = last;
        rr_found = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((int'(last) + i) % NUM_CH);
            if (!rr_found && DmacReq[cand]) begin
                rr_sel   = cand;
                rr_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_n   = state;
        bus_req_n = Bus_Req;
        ack_n     = '0;
        en_n      = Ch_En;
        sel_n     = Ch_Sel;
        last_n    = last;
        done_set  = 1'b0;
        err_set   = 1'b0;

        case (state)
            IDLE: begin
                if (rr_found) begin
                    sel_n     = rr_sel;
                    bus_req_n = 1'b1;
                    state_n   = REQ_BUS;
                end
            end
            REQ_BUS: begin
                // Selection is frozen here; only a withdrawal or grant moves on.
                if (!DmacReq[Ch_Sel]) begin
                    bus_req_n = 1'b0;
                    state_n   = IDLE;
                end else if (Bus_Grant) begin
                    ack_n   = onehot(Ch_Sel);
                    en_n    = onehot(Ch_Sel);
                    state_n = ACK;
                end
            end
            ACK: begin
                state_n = ACTIVE;
            end
            ACTIVE: begin
                if (Ch_Done || Ch_Error) begin
                    done_set  = Ch_Done;
                    err_set   = Ch_Error;
                    en_n      = '0;
                    bus_req_n = 1'b0;
                    last_n    = Ch_Sel;
                    state_n   = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                // Corrupted encoding: drop the bus and any enable, restart.
                en_n      = '0;
                bus_req_n = 1'b0;
                state_n   = IDLE;
            end
        endcase

        // A set event in the same cycle as a clear takes precedence.
        int_stat_n = (Int_Clr ? '0 : Int_Status) | (done_set ? onehot(Ch_Sel) : '0);
        err_stat_n = (Int_Clr ? '0 : Err_Status) | (err_set  ? onehot(Ch_Sel) : '0);
        irq_n      = (Int_Clr ? 1'b0 : Interrupt) | done_set | err_set;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Registered outputs, status flags and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Bus_Req    <= 1'b0;
            ReqAck     <= '0;
            Ch_En      <= '0;
            Ch_Sel     <= '0;
            Interrupt  <= 1'b0;
            Int_Status <= '0;
            Err_Status <= '0;
            last       <= CH_W'(NUM_CH - 1);
        end else begin
            Bus_Req    <= bus_req_n;
            ReqAck     <= ack_n;
            Ch_En      <= en_n;
            Ch_Sel     <= sel_n;
            Interrupt  <= irq_n;
            Int_Status <= int_stat_n;
            Err_Status <= err_stat_n;
            last       <= last_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmac_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmac_channel_arbiter
// Description : Directed self-checking bench for dmac_channel_arbiter with
//               hand-computed expectations (two channels).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmac_channel_arbiter;

    localparam int NUM_CH = 2;
    localparam int CH_W   = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] DmacReq = '0;
    logic              Bus_Grant = 1'b0;
    logic              Ch_Done = 1'b0;
    logic              Ch_Error = 1'b0;
    logic              Int_Clr = 1'b0;
    logic              Bus_Req;
    logic [NUM_CH-1:0] ReqAck;
    logic [NUM_CH-1:0] Ch_En;
    logic [CH_W-1:0]   Ch_Sel;
    logic              Ch_Hold;
    logic              Interrupt;
    logic [NUM_CH-1:0] Int_Status;
    logic [NUM_CH-1:0] Err_Status;

    int total = 0;
    int bad   = 0;

    dmac_channel_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .DmacReq    (DmacReq),
        .Bus_Grant  (Bus_Grant),
        .Ch_Done    (Ch_Done),
        .Ch_Error   (Ch_Error),
        .Int_Clr    (Int_Clr),
        .Bus_Req    (Bus_Req),
        .ReqAck     (ReqAck),
        .Ch_En      (Ch_En),
        .Ch_Sel     (Ch_Sel),
        .Ch_Hold    (Ch_Hold),
        .Interrupt  (Interrupt),
        .Int_Status (Int_Status),
        .Err_Status (Err_Status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stop a runaway simulation.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_bus_req", Bus_Req, 0);
        check("rst_ch_en", Ch_En, 0);
        check("rst_reqack", ReqAck, 0);
        check("rst_irq", Interrupt, 0);
        check("rst_status", {Int_Status, Err_Status}, 0);
        rst = 1'b0;

        // ---------------- round robin 0,1,0,1 ----------------
        Bus_Grant = 1'b1;
        DmacReq   = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();                                         // REQ_BUS
            check("rr_bus_req", Bus_Req, 1);
            check("rr_sel", Ch_Sel, i % 2);
            tick();                                         // ACK
            check("rr_ack", ReqAck, 1 << (i % 2));
            check("rr_en", Ch_En, 1 << (i % 2));
            tick();                                         // ACTIVE
            check("rr_ack_gone", ReqAck, 0);
            Ch_Done = 1'b1;
            tick();                                         // DONE
            Ch_Done = 1'b0;
            check("rr_gap_done", Bus_Req, 0);
            check("rr_en_off", Ch_En, 0);
            tick();                                         // IDLE
            check("rr_gap_idle", Bus_Req, 0);
            if (i == 3) DmacReq = 2'b00;
        end
        check("rr_int_status", Int_Status, 2'b11);

        // ---------------- withdrawal ----------------
        Bus_Grant = 1'b0;
        DmacReq   = 2'b10;
        tick();
        check("wd_bus_req", Bus_Req, 1);
        check("wd_sel", Ch_Sel, 1);
        repeat (4) tick();
        check("wd_no_ack", ReqAck, 0);
        check("wd_still_req", Bus_Req, 1);
        DmacReq = 2'b00;
        tick();
        check("wd_bus_drop", Bus_Req, 0);
        check("wd_no_ack2", ReqAck, 0);
        tick();
        DmacReq   = 2'b11;
        Bus_Grant = 1'b1;
        tick();
        check("wd_next_sel", Ch_Sel, 0);
        tick();
        check("wd_next_ack", ReqAck, 2'b01);
        DmacReq = 2'b00;
        tick();                                             // ACTIVE
        check("gl_hold_before", Ch_Hold, 0);

        // ---------------- grant loss in ACTIVE ----------------
        Bus_Grant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("gl_hold", Ch_Hold, 1);
            check("gl_en", Ch_En, 2'b01);
            check("gl_bus_req", Bus_Req, 1);
            tick();
        end
        Bus_Grant = 1'b1;
        #1;
        check("gl_hold_after", Ch_Hold, 0);
        check("gl_en_after", Ch_En, 2'b01);
        Ch_Done = 1'b1;
        tick();                                             // DONE
        Ch_Done = 1'b0;
        check("gl_done_en", Ch_En, 0);
        check("gl_done_status", Int_Status, 2'b11);
        tick();                                             // IDLE

        // ---------------- error and clear ----------------
        Int_Clr = 1'b1;
        tick();
        Int_Clr = 1'b0;
        check("clr_irq", Interrupt, 0);
        check("clr_status", {Int_Status, Err_Status}, 0);
        DmacReq = 2'b10;
        tick();
        check("err_sel", Ch_Sel, 1);
        tick();
        check("err_ack", ReqAck, 2'b10);
        DmacReq = 2'b00;
        tick();                                             // ACTIVE
        Ch_Error = 1'b1;
        tick();                                             // DONE
        Ch_Error = 1'b0;
        check("err_status", Err_Status, 2'b10);
        check("err_irq", Interrupt, 1);
        check("err_int_status", Int_Status, 2'b00);
        tick();                                             // IDLE
        DmacReq = 2'b01;
        tick();
        check("ec_sel", Ch_Sel, 0);
        tick();
        DmacReq = 2'b00;
        tick();                                             // ACTIVE
        Ch_Done = 1'b1;
        Int_Clr = 1'b1;
        tick();                                             // DONE
        Ch_Done = 1'b0;
        Int_Clr = 1'b0;
        check("ec_int_status", Int_Status, 2'b01);
        check("ec_err_status", Err_Status, 2'b00);
        check("ec_irq", Interrupt, 1);
        tick();                                             // IDLE

        // Done pulse outside ACTIVE must be ignored.
        Ch_Error = 1'b1;
        Ch_Done  = 1'b1;
        tick();
        Ch_Error = 1'b0;
        Ch_Done  = 1'b0;
        check("stray_err", Err_Status, 2'b00);
        check("stray_bus", Bus_Req, 0);

        // ---------------- reset mid-transfer ----------------
        DmacReq = 2'b01;
        tick();
        tick();
        DmacReq = 2'b00;
        tick();                                             // ACTIVE
        check("mr_pre_en", Ch_En, 2'b01);
        #3;
        rst = 1'b1;
        #1;
        check("mr_en", Ch_En, 0);
        check("mr_bus_req", Bus_Req, 0);
        check("mr_irq", Interrupt, 0);
        check("mr_status", {Int_Status, Err_Status}, 0);
        tick();
        tick();
        rst       = 1'b0;
        Bus_Grant = 1'b0;

        // ---------------- single request with exact latencies ----------------
        DmacReq = 2'b01;                                    // cycle t
        tick();                                             // t+1
        check("sr_bus_req_t1", Bus_Req, 1);
        check("sr_sel", Ch_Sel, 0);
        tick();                                             // t+2
        check("sr_no_ack_t2", ReqAck, 0);
        tick();                                             // t+3
        check("sr_no_ack_t3", ReqAck, 0);
        Bus_Grant = 1'b1;
        tick();                                             // t+4
        check("sr_ack_t4", ReqAck, 2'b01);
        check("sr_en_t4", Ch_En, 2'b01);
        DmacReq = 2'b00;
        tick();                                             // t+5
        check("sr_ack_t5", ReqAck, 0);
        check("sr_en_t5", Ch_En, 2'b01);
        repeat (18) tick();
        check("sr_irq_pre", Interrupt, 0);
        check("sr_bus_pre", Bus_Req, 1);
        Ch_Done = 1'b1;
        tick();
        Ch_Done = 1'b0;
        check("sr_irq", Interrupt, 1);
        check("sr_int_status", Int_Status, 2'b01);
        check("sr_bus_req_done", Bus_Req, 0);
        check("sr_en_done", Ch_En, 0);
        tick();
        check("sr_idle_bus", Bus_Req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmac_channel_arbiter.md
Name: dmac_channel_arbiter

Overview:
- Round-robin channel arbiter and sequencer for the DMAC.
- Samples the peripheral request lines, requests the system bus, and acknowledges the winning peripheral.
- Enables exactly one channel engine at a time and raises the completion interrupt when that channel finishes.
- Sits between DmacReq/Bus_Grant at the Dmac_Top boundary and the per-channel transfer engines.

Parameters:
- NUM_CH, 2: number of DMA channels/request lines (2..8).
- CH_W, $clog2(NUM_CH): width of the channel index.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- DmacReq  in  NUM_CH  level request per peripheral; bit i = channel i.
- Bus_Grant  in  1  bus granted to DMAC by the system arbiter.
- Ch_Done  in  1  one-cycle pulse from the active channel engine: transfer size reached.
- Ch_Error  in  1  one-cycle pulse from the active engine: AHB ERROR response seen.
- Int_Clr  in  1  one-cycle pulse; clears Interrupt and status.
- Bus_Req  out  1  bus request to the system arbiter.
- ReqAck  out  NUM_CH  one-cycle acknowledge pulse to the winning peripheral.
- Ch_En  out  NUM_CH  one-hot enable of the active channel engine.
- Ch_Sel  out  CH_W  index of the active/last-selected channel.
- Ch_Hold  out  1  stall to the active engine while the grant is withdrawn.
- Interrupt  out  1  sticky completion interrupt.
- Int_Status  out  NUM_CH  sticky per-channel done flags.
- Err_Status  out  NUM_CH  sticky per-channel error flags.

Behaviour:
- Registered outputs: Bus_Req, ReqAck, Ch_En, Ch_Sel, Interrupt, Int_Status, Err_Status. Ch_Hold is combinational, = Ch_En!=0 && !Bus_Grant.
- Reset values: all outputs 0. FSM=IDLE. Round-robin pointer last=NUM_CH-1, so channel 0 has first priority.
- FSM states: IDLE, REQ_BUS, ACK, ACTIVE, DONE.
- IDLE:
  - If DmacReq!=0, select the first set bit searching from last+1 upward with wrap-around.
  - Latch the selection into Ch_Sel, set Bus_Req=1, go to REQ_BUS. Latency: request in cycle t -> Bus_Req high in cycle t+1.
- REQ_BUS:
  - If DmacReq[Ch_Sel] drops before grant: Bus_Req=0, return to IDLE. No ack, pointer unchanged.
  - Else if Bus_Grant=1: go to ACK.
  - Selection is frozen; new or higher-priority requests do not pre-empt.
- ACK:
  - Exactly one cycle: ReqAck[Ch_Sel]=1 and Ch_En[Ch_Sel]=1 in the same cycle, then go to ACTIVE.
  - Grant in cycle g -> ReqAck visible in cycle g+1.
- ACTIVE:
  - Ch_En and Bus_Req held. DmacReq is ignored; the peripheral deasserts on ReqAck.
  - Bus_Grant low -> Ch_Hold=1 while state is kept.
  - Ch_Done or Ch_Error -> go to DONE. If both arrive together, both are recorded.
- DONE (one cycle):
  - Ch_En=0, Bus_Req=0, last<=Ch_Sel.
  - Int_Status[Ch_Sel] set on Done; Err_Status[Ch_Sel] set on Error; Interrupt set in either case. Then go to IDLE.
  - Interrupt rises in the cycle after the Done/Error pulse.
- Bus_Req is low for at least one cycle between consecutive channels, giving the system arbiter a chance to re-arbitrate.
- Int_Clr clears Interrupt, Int_Status and Err_Status.
  - If a set event occurs in the same cycle as Int_Clr, the set wins for that channel's bits and Interrupt stays 1.
- Interrupt and status do not block new arbitration.
- Ch_Done/Ch_Error outside ACTIVE are ignored.
- Async rst mid-transfer: immediately forces all outputs to 0 and FSM to IDLE. The engine must treat Ch_En falling as an abort.
- Unknown/illegal FSM encodings recover to IDLE.

Test Plan:
- Single request: DmacReq=01 at t, Bus_Grant=1 at t+3, Ch_Done pulse 20 cycles later.
  - Required: Bus_Req high t+1.
  - ReqAck=01 for exactly 1 cycle at t+4, same cycle as Ch_En=01.
  - Interrupt=1 and Int_Status=01 one cycle after Ch_Done; Bus_Req=0 that cycle.
- Round-robin: DmacReq=11 held, grant always high, Ch_Done after each enable.
  - Required: Ch_Sel sequence 0,1,0,1, with Bus_Req low at least 1 cycle between channels.
- Withdrawal: DmacReq=10, Bus_Grant held 0, drop DmacReq after 5 cycles.
  - Required: Bus_Req returns to 0, no ReqAck.
  - Next DmacReq=11 serves channel 0 first, because the pointer is unchanged.
- Grant loss: in ACTIVE drop Bus_Grant for 4 cycles.
  - Required: Ch_Hold=1 for exactly those 4 cycles, Ch_En unchanged, no state change.
- Error and clear:
  - Ch_Error on channel 1 -> Err_Status=10, Interrupt=1.
  - Int_Clr coincident with a later channel-0 Ch_Done -> Int_Status=01, Err_Status=00, Interrupt stays 1.
- Reset mid-transfer: assert rst asynchronously (between edges) during ACTIVE.
  - Required: Ch_En, Bus_Req, Interrupt go to 0 immediately.
  - After release with DmacReq=01, the normal sequence restarts from IDLE.
